// File: rtl/mult_acc_stage_if.sv
// Handshake bundle between the multiplier result, the accumulate stage and its consumer.
// The slave modport is the accumulate stage; the master modport is the product source / sum sink.
interface mult_acc_stage_if #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24
);
    logic                   in_valid;
    logic                   in_ready;
    logic [2*WIDTH-1:0]     product;
    logic                   in_last;
    logic                   out_valid;
    logic                   out_ready;
    logic [ACC_WIDTH-1:0]   acc_out;
    logic                   overflow;

    modport slave (
        input  in_valid, product, in_last, out_ready,
        output in_ready, out_valid, acc_out, overflow
    );

    modport master (
        output in_valid, product, in_last, out_ready,
        input  in_ready, out_valid, acc_out, overflow
    );
endinterface

// File: rtl/mult_acc_stage.sv
// Accumulates groups of unsigned products into ACC_WIDTH-bit sums with valid/ready on both sides.
// Define MULT_ACC_SATURATE_EN to clamp the sum at all-ones on carry instead of wrapping.
module mult_acc_stage #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 24,
    parameter int LEN       = 4
) (
    input  logic             clk,
    input  logic             clr,
    mult_acc_stage_if.slave  bus
);
    localparam int CW = $clog2(LEN + 1);
    localparam logic [CW-1:0] LAST_CNT = CW'(LEN - 1);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]           state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [ACC_WIDTH-1:0] acc_out_q, acc_out_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 overflow_q, overflow_d;

    logic [ACC_WIDTH-1:0] prod_ext;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;
    logic [ACC_WIDTH-1:0] acc_next;
    logic                 in_hs;
    logic                 out_hs;

    assign prod_ext = ACC_WIDTH'(bus.product);
    assign sum      = {1'b0, acc_q} + {1'b0, prod_ext};
    assign carry    = sum[ACC_WIDTH];

`ifdef MULT_ACC_SATURATE_EN
    // Sticky overflow keeps the group clamped even if later products are zero.
    assign acc_next = (carry || overflow_q) ? '1 : sum[ACC_WIDTH-1:0];
`else
    assign acc_next = sum[ACC_WIDTH-1:0];
`endif

    assign bus.in_ready  = !clr && ((state_q == ACCUM) || bus.out_ready);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.acc_out   = acc_out_q;
    assign bus.overflow  = overflow_q;

    assign in_hs  = bus.in_valid && bus.in_ready;
    assign out_hs = bus.out_valid && bus.out_ready;

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        acc_out_d  = acc_out_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        case (state_q)
            ACCUM: begin
                if (in_hs) begin
                    acc_d      = acc_next;
                    count_d    = count_q + 1'b1;
                    overflow_d = overflow_q | carry;
                    if ((count_q == LAST_CNT) || bus.in_last) begin
                        state_d   = HOLD;
                        acc_out_d = acc_next;
                    end
                end
            end
            default: begin
                if (out_hs) begin
                    overflow_d = 1'b0;
                    if (in_hs) begin
                        // A single product cannot carry since ACC_WIDTH >= 2*WIDTH.
                        acc_d   = prod_ext;
                        count_d = CW'(1);
                        if ((LEN == 1) || bus.in_last) begin
                            state_d   = HOLD;
                            acc_out_d = prod_ext;
                        end else begin
                            state_d = ACCUM;
                        end
                    end else begin
                        acc_d   = '0;
                        count_d = '0;
                        state_d = ACCUM;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= ACCUM;
            acc_q      <= '0;
            acc_out_q  <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            acc_out_q  <= acc_out_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end
endmodule

// File: tb/tb_mult_acc_stage.sv
// Directed bench for mult_acc_stage: a LEN=4/24-bit instance and a LEN=2/16-bit instance,
// expected group sums queued when products are driven and checked on each output handshake.
module tb_mult_acc_stage;
    logic clk = 1'b0;
    logic clr;
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    mult_acc_stage_if #(.WIDTH(8), .ACC_WIDTH(24)) i0 ();
    mult_acc_stage_if #(.WIDTH(8), .ACC_WIDTH(16)) i1 ();

    mult_acc_stage #(.WIDTH(8), .ACC_WIDTH(24), .LEN(4)) dut0 (.clk(clk), .clr(clr), .bus(i0.slave));
    mult_acc_stage #(.WIDTH(8), .ACC_WIDTH(16), .LEN(2)) dut1 (.clk(clk), .clr(clr), .bus(i1.slave));

    logic [24:0] q0[$];
    logic [24:0] q1[$];
    longint      m_acc[2];
    int          m_cnt[2];
    bit          m_ovf[2];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset(input int which);
        m_acc[which] = 0;
        m_cnt[which] = 0;
        m_ovf[which] = 1'b0;
    endtask

    // Model the group sum, then drive one product and wait for its handshake.
    task automatic send(input int which, input logic [15:0] p, input bit last);
        longint s;
        longint lim;
        int     len;
        bit     ok;
        lim = (which == 1) ? 64'd65536 : 64'd16777216;
        len = (which == 1) ? 2 : 4;
        ok  = 1'b0;
        s   = m_acc[which] + longint'(p);
        if (s >= lim) begin
            m_ovf[which] = 1'b1;
`ifdef MULT_ACC_SATURATE_EN
            s = lim - 1;
`else
            s = s - lim;
`endif
        end
        m_acc[which] = s;
        m_cnt[which]++;
        if (m_cnt[which] == len || last) begin
            if (which == 1) q1.push_back({m_ovf[which], s[23:0]});
            else            q0.push_back({m_ovf[which], s[23:0]});
            model_reset(which);
        end
        if (which == 1) begin
            i1.in_valid = 1'b1; i1.product = p; i1.in_last = last;
        end else begin
            i0.in_valid = 1'b1; i0.product = p; i0.in_last = last;
        end
        for (int k = 0; k < 50 && !ok; k++) begin
            #1;
            ok = (which == 1) ? i1.in_ready : i0.in_ready;
            @(posedge clk);
            @(negedge clk);
        end
        if (!ok) check("send_timeout", 32'd0, 32'd1);
        if (which == 1) begin
            i1.in_valid = 1'b0; i1.in_last = 1'b0;
        end else begin
            i0.in_valid = 1'b0; i0.in_last = 1'b0;
        end
    endtask

    always @(negedge clk) begin
        #2;
        if (i0.out_valid && i0.out_ready) begin
            if (q0.size() == 0) check("unexpected_out0", 32'd1, 32'd0);
            else begin
                logic [24:0] e;
                e = q0.pop_front();
                check("acc_out0", 32'(i0.acc_out), 32'(e[23:0]));
                check("overflow0", 32'(i0.overflow), 32'(e[24]));
            end
        end
        if (i1.out_valid && i1.out_ready) begin
            if (q1.size() == 0) check("unexpected_out1", 32'd1, 32'd0);
            else begin
                logic [24:0] e;
                e = q1.pop_front();
                check("acc_out1", 32'(i1.acc_out), 32'(e[23:0]));
                check("overflow1", 32'(i1.overflow), 32'(e[24]));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        clr = 1'b1;
        i0.in_valid = 1'b0; i0.product = '0; i0.in_last = 1'b0; i0.out_ready = 1'b1;
        i1.in_valid = 1'b0; i1.product = '0; i1.in_last = 1'b0; i1.out_ready = 1'b1;
        model_reset(0);
        model_reset(1);
        repeat (2) @(negedge clk);
        #1;
        check("rst_in_ready", 32'(i0.in_ready), 32'd0);
        check("rst_out_valid", 32'(i0.out_valid), 32'd0);
        check("rst_acc_out", 32'(i0.acc_out), 32'd0);
        check("rst_overflow", 32'(i0.overflow), 32'd0);
        clr = 1'b0;
        #1;
        check("post_rst_in_ready", 32'(i0.in_ready), 32'd1);
        @(negedge clk);

        // Basic group and one-cycle output latency.
        send(0, 16'd100, 1'b0);
        send(0, 16'd200, 1'b0);
        send(0, 16'd300, 1'b0);
        #1 check("basic_not_yet_valid", 32'(i0.out_valid), 32'd0);
        send(0, 16'd400, 1'b0);
        #1 check("basic_valid_latency", 32'(i0.out_valid), 32'd1);
        @(negedge clk);

        // Early close, then a full group, then a one-product group.
        send(0, 16'd5, 1'b0);
        send(0, 16'd6, 1'b1);
        for (int i = 0; i < 4; i++) send(0, 16'd1, 1'b0);
        send(0, 16'd42, 1'b1);
        @(negedge clk);

        // Backpressure: completed sum held, later products ignored.
        i0.out_ready = 1'b0;
        send(0, 16'd10, 1'b0);
        send(0, 16'd20, 1'b0);
        send(0, 16'd30, 1'b0);
        send(0, 16'd40, 1'b0);
        i0.in_valid = 1'b1;
        i0.product  = 16'd999;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("bp_out_valid", 32'(i0.out_valid), 32'd1);
            check("bp_acc_out", 32'(i0.acc_out), 32'd100);
            check("bp_in_ready", 32'(i0.in_ready), 32'd0);
            i0.product = i0.product + 16'd1;
            @(negedge clk);
        end
        i0.in_valid  = 1'b0;
        i0.out_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_release_out_valid", 32'(i0.out_valid), 32'd0);
        check("bp_release_in_ready", 32'(i0.in_ready), 32'd1);
        @(negedge clk);

        // Back-to-back groups with no bubble cycles.
        send(0, 16'd1, 1'b0);
        send(0, 16'd2, 1'b0);
        send(0, 16'd3, 1'b0);
        send(0, 16'd4, 1'b0);
        begin
            int c0;
            c0 = cyc;
            send(0, 16'd7, 1'b0);
            send(0, 16'd1, 1'b0);
            send(0, 16'd1, 1'b0);
            send(0, 16'd1, 1'b0);
            check("b2b_cycles", 32'(cyc - c0), 32'd4);
        end
        // Simultaneous handshake with in_last stays in HOLD for a one-product group.
        send(0, 16'd9, 1'b1);
        #1 check("b2b_last_hold", 32'(i0.out_valid), 32'd1);
        @(negedge clk);

        // Overflow on the 16-bit, LEN=2 instance.
        send(1, 16'd65025, 1'b0);
        send(1, 16'd65025, 1'b0);
        @(negedge clk);
        #1;
        check("ovf_cleared", 32'(i1.overflow), 32'd0);
        check("ovf_out_valid_low", 32'(i1.out_valid), 32'd0);
        @(negedge clk);

        // Asynchronous clear mid-group discards the partial sum.
        send(0, 16'd50, 1'b0);
        send(0, 16'd60, 1'b0);
        #1 clr = 1'b1;
        #1;
        check("midrst_acc_out", 32'(i0.acc_out), 32'd0);
        check("midrst_out_valid", 32'(i0.out_valid), 32'd0);
        check("midrst_overflow", 32'(i0.overflow), 32'd0);
        check("midrst_in_ready", 32'(i0.in_ready), 32'd0);
        #1 clr = 1'b0;
        model_reset(0);
        @(negedge clk);
        send(0, 16'd1, 1'b0);
        send(0, 16'd2, 1'b0);
        send(0, 16'd3, 1'b0);
        send(0, 16'd4, 1'b0);
        repeat (3) @(negedge clk);

        check("q0_drained", 32'(q0.size()), 32'd0);
        check("q1_drained", 32'(q1.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
